// File: rtl/overlap_pkg.sv
// Shared types and saturation helper for the multi-channel overlap-add stage.
// Mode encodings match the 2-bit block mode sampled with sample 0 of each block.
package overlap_pkg;

  typedef enum logic [1:0] {
    OVL_NORMAL = 2'b00,
    OVL_FIRST  = 2'b01,
    OVL_LAST   = 2'b10,
    OVL_BYPASS = 2'b11
  } ovl_mode_e;

  typedef enum logic {
    ST_OVERLAP = 1'b0,
    ST_STORE   = 1'b1
  } ovl_state_e;

  // Widest sample the saturation helper supports; callers sign-extend into it.
  localparam int SAT_W = 64;

  // Clamp a signed sum to a signed range of 'width' bits.
  // Result: bit SAT_W is the clip flag, bits [SAT_W-1:0] hold the clamped value.
  function automatic logic [SAT_W:0] saturate(input logic signed [SAT_W:0] sum,
                                              input int width);
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    one    = '0;
    one[0] = 1'b1;
    hi     = (one <<< (width - 1)) - one;
    lo     = -(one <<< (width - 1));
    if (sum > hi) begin
      saturate = {1'b1, hi[SAT_W-1:0]};
    end else if (sum < lo) begin
      saturate = {1'b1, lo[SAT_W-1:0]};
    end else begin
      saturate = {1'b0, sum[SAT_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/overlap_hist_bank.sv
// Per-channel history of the previous block's second half: CHANNELS x HALF_LEN samples.
// Combinational read, single registered write, asynchronous clear on reset.
module overlap_hist_bank #(
  parameter int DATA_W   = 32,
  parameter int HALF_LEN = 18,
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1,
  parameter int IDX_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_dat,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_dat
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

  logic [DATA_W-1:0] mem [CHANNELS][HALF_LEN];
  logic              rd_ch_ok;
  logic              wr_ch_ok;

  // Channel codes beyond CHANNELS (non power-of-two builds) read zero and never write.
  assign rd_ch_ok = ({1'b0, rd_ch} < CH_LIMIT);
  assign wr_ch_ok = ({1'b0, wr_ch} < CH_LIMIT);

  always_comb begin
    rd_dat = '0;
    if (rd_ch_ok) begin
      rd_dat = mem[rd_ch][rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < HALF_LEN; i++) begin
          mem[c][i] <= '0;
        end
      end
    end else if (wr_en && wr_ch_ok) begin
      mem[wr_ch][wr_idx] <= wr_dat;
    end
  end

endmodule

// File: rtl/overlap_add_mc.sv
// Multi-channel overlap-add: first half of each block plus stored history -> HALF_LEN PCM samples, 1-cycle latency.
// Input stalls in OVERLAP only while the single output register is full and not drained; STORE always accepts.
module overlap_add_mc
  import overlap_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int HALF_LEN = 18,
  parameter int CHANNELS = 2,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        in_overlap_firstSequence,
  input  logic [CH_W-1:0]   in_overlap_channel,
  input  logic [DATA_W-1:0] in_overlap_pcmSample,
  input  logic              in_overlap_valid,
  output logic              in_overlap_ready,
  output logic [DATA_W-1:0] out_overlap_pcmSample,
  output logic [CH_W-1:0]   out_overlap_channel,
  output logic              out_overlap_last,
  output logic              out_overlap_valid,
  input  logic              out_overlap_ready,
  output logic              sat_pulse,
  output logic              busy
);

  localparam int IDX_W = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF_LEN - 1);

  ovl_state_e        state_q;
  ovl_state_e        state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  ovl_mode_e         mode_q;
  logic [CH_W-1:0]   ch_q;

  logic              sample0;
  ovl_mode_e         cur_mode;
  logic [CH_W-1:0]   cur_ch;
  logic              xfer;
  logic              ovl_xfer;
  logic              hist_we;
  logic [DATA_W-1:0] hist_wdat;
  logic [DATA_W-1:0] hist_rdat;

  logic [DATA_W-1:0]       addend;
  logic signed [DATA_W:0]  sum_w;
  logic signed [SAT_W:0]   sum_ext;
  logic [SAT_W:0]          sat_res;
  logic [SAT_W-DATA_W-1:0] sat_unused_bits;

  // Mode and channel come straight from the port on sample 0, from the latch afterwards.
  assign sample0  = (state_q == ST_OVERLAP) && (idx_q == '0);
  assign cur_mode = sample0 ? ovl_mode_e'(in_overlap_firstSequence) : mode_q;
  assign cur_ch   = sample0 ? in_overlap_channel : ch_q;
  assign xfer     = in_overlap_valid && in_overlap_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OVERLAP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (xfer) begin
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        state_d = (state_q == ST_OVERLAP) ? ST_STORE : ST_OVERLAP;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // FSM outputs; ready is forced low while reset is held.
  always_comb begin
    in_overlap_ready = 1'b0;
    ovl_xfer         = 1'b0;
    hist_we          = 1'b0;
    hist_wdat        = in_overlap_pcmSample;
    busy             = (state_q == ST_STORE) || (idx_q != '0);
    case (state_q)
      ST_OVERLAP: begin
        in_overlap_ready = reset && (!out_overlap_valid || out_overlap_ready);
        ovl_xfer         = xfer;
      end
      ST_STORE: begin
        in_overlap_ready = reset;
        hist_we          = xfer && (mode_q != OVL_BYPASS);
        if (mode_q == OVL_LAST) begin
          hist_wdat = '0;
        end
      end
      default: begin
        in_overlap_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= OVL_NORMAL;
      ch_q   <= '0;
    end else if (xfer && sample0) begin
      mode_q <= ovl_mode_e'(in_overlap_firstSequence);
      ch_q   <= in_overlap_channel;
    end
  end

  overlap_hist_bank #(
    .DATA_W   (DATA_W),
    .HALF_LEN (HALF_LEN),
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W),
    .IDX_W    (IDX_W)
  ) u_hist (
    .clk    (clk),
    .reset  (reset),
    .rd_ch  (cur_ch),
    .rd_idx (idx_q),
    .rd_dat (hist_rdat),
    .wr_en  (hist_we),
    .wr_ch  (ch_q),
    .wr_idx (idx_q),
    .wr_dat (hist_wdat)
  );

  // First and bypass blocks ignore history; one extra bit keeps the sum exact before clamping.
  assign addend  = ((cur_mode == OVL_NORMAL) || (cur_mode == OVL_LAST)) ? hist_rdat : '0;
  assign sum_w   = $signed({in_overlap_pcmSample[DATA_W-1], in_overlap_pcmSample})
                 + $signed({addend[DATA_W-1], addend});
  assign sum_ext = {{(SAT_W - DATA_W){sum_w[DATA_W]}}, sum_w};
  assign sat_res = saturate(sum_ext, DATA_W);
  assign sat_unused_bits = sat_res[SAT_W-1:DATA_W];

  // Single output register: a new sample may replace one draining in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_overlap_valid     <= 1'b0;
      out_overlap_pcmSample <= '0;
      out_overlap_channel   <= '0;
      out_overlap_last      <= 1'b0;
      sat_pulse             <= 1'b0;
    end else begin
      sat_pulse <= 1'b0;
      if (ovl_xfer) begin
        out_overlap_valid     <= 1'b1;
        out_overlap_pcmSample <= sat_res[DATA_W-1:0];
        out_overlap_channel   <= cur_ch;
        out_overlap_last      <= (idx_q == IDX_LAST);
        sat_pulse             <= sat_res[SAT_W];
      end else if (out_overlap_ready) begin
        out_overlap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_overlap_add_mc.sv
// Scoreboard bench for overlap_add_mc (HALF_LEN=4, CHANNELS=2, DATA_W=16).
// Stimulus pushes expected outputs; a negedge monitor pops on each output handshake.
module tb_overlap_add_mc;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         in_mode;
  logic [0:0]         in_ch;
  logic signed [15:0] in_dat;
  logic               in_vld;
  logic               in_rdy;
  logic signed [15:0] out_dat;
  logic [0:0]         out_ch;
  logic               out_last;
  logic               out_vld;
  logic               out_rdy;
  logic               sat_pulse;
  logic               busy;

  typedef struct {
    int data;
    int ch;
    bit last;
    bit sat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   sat_seen = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  overlap_add_mc #(
    .DATA_W   (16),
    .HALF_LEN (4),
    .CHANNELS (2)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .in_overlap_firstSequence (in_mode),
    .in_overlap_channel       (in_ch),
    .in_overlap_pcmSample     (in_dat),
    .in_overlap_valid         (in_vld),
    .in_overlap_ready         (in_rdy),
    .out_overlap_pcmSample    (out_dat),
    .out_overlap_channel      (out_ch),
    .out_overlap_last         (out_last),
    .out_overlap_valid        (out_vld),
    .out_overlap_ready        (out_rdy),
    .sat_pulse                (sat_pulse),
    .busy                     (busy)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void push_exp(input int d, input int ch, input bit last, input bit sat);
    exp_t e;
    e.data = d;
    e.ch   = ch;
    e.last = last;
    e.sat  = sat;
    sb_q.push_back(e);
  endfunction

  // Monitor: a handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (reset) begin
      if (sat_pulse) sat_seen = 1'b1;
      if (out_vld && out_rdy) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected no output", out_dat);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_data", int'(out_dat), mon_e.data);
          check("out_ch", int'(out_ch), mon_e.ch);
          check("out_last", int'(out_last), int'(mon_e.last));
          check("out_sat", int'(sat_seen), int'(mon_e.sat));
        end
        sat_seen = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [1:0] m, input logic ch, input int d);
    int n;
    in_mode = m;
    in_ch   = ch;
    in_dat  = 16'(d);
    in_vld  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_overlap_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  // Later samples carry a wrong channel and mode to prove both are latched at sample 0.
  task automatic send_block(input logic [1:0] m, input logic ch, input int d[8],
                            input int e[4], input logic [3:0] s);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) push_exp(e[i], int'(ch), (i == 3), s[i]);
      send((i == 0) ? m : ~m, (i == 0) ? ch : ~ch, d[i]);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("queue_drained", sb_q.size(), 0);
  endtask

  initial begin
    reset   = 1'b0;
    in_mode = 2'b00;
    in_ch   = 1'b0;
    in_dat  = '0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_rdy", int'(in_rdy), 0);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_dat", int'(out_dat), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sat", int'(sat_pulse), 0);
    reset = 1'b1;
    #1;
    check("rdy_after_rst", int'(in_rdy), 1);
    @(posedge clk);
    #1;

    // First block seeds ch0 history, then normal blocks on ch0 and ch1.
    send_block(2'b01, 1'b0, '{1, 2, 3, 4, 10, 20, 30, 40}, '{1, 2, 3, 4}, 4'b0000);
    send_block(2'b00, 1'b0, '{5, 5, 5, 5, 0, 0, 0, 0}, '{15, 25, 35, 45}, 4'b0000);
    send_block(2'b00, 1'b1, '{1, 1, 1, 1, 0, 0, 0, 0}, '{1, 1, 1, 1}, 4'b0000);

    // Saturation both directions.
    send_block(2'b01, 1'b0, '{0, 0, 0, 0, 32000, -32000, 0, 0}, '{0, 0, 0, 0}, 4'b0000);
    send_block(2'b00, 1'b0, '{1000, -1000, 0, 0, 0, 0, 0, 0}, '{32767, -32768, 0, 0}, 4'b0011);

    // Bypass leaves history alone; last clears it.
    send_block(2'b01, 1'b0, '{0, 0, 0, 0, 1, 2, 3, 4}, '{0, 0, 0, 0}, 4'b0000);
    send_block(2'b11, 1'b0, '{7, 7, 7, 7, 9, 9, 9, 9}, '{7, 7, 7, 7}, 4'b0000);
    send_block(2'b10, 1'b0, '{10, 10, 10, 10, 99, 99, 99, 99}, '{11, 12, 13, 14}, 4'b0000);
    send_block(2'b00, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0}, 4'b0000);
    drain(20);

    // Output stall mid-OVERLAP on ch1 (history zero).
    out_rdy = 1'b0;
    push_exp(100, 1, 1'b0, 1'b0);
    send(2'b00, 1'b1, 100);
    fork
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_rdy", int'(in_rdy), 0);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
      begin
        push_exp(200, 1, 1'b0, 1'b0);
        send(2'b11, 1'b0, 200);
      end
    join
    push_exp(300, 1, 1'b0, 1'b0);
    send(2'b11, 1'b0, 300);
    push_exp(400, 1, 1'b1, 1'b0);
    send(2'b11, 1'b0, 400);

    // Output stalled across the whole STORE phase; input keeps flowing.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("store_in_rdy", int'(in_rdy), 1);
      check("store_out_hold", int'(out_vld), 1);
      @(posedge clk);
      #1;
      send(2'b11, 1'b0, 5 + i);
    end
    check("busy_after_store", int'(busy), 0);
    out_rdy = 1'b1;
    send_block(2'b10, 1'b1, '{1, 1, 1, 1, 0, 0, 0, 0}, '{6, 7, 8, 9}, 4'b0000);
    drain(20);

    // Reset at idx 2 of STORE discards the partial block and clears history.
    push_exp(1, 0, 1'b0, 1'b0);
    send(2'b01, 1'b0, 1);
    push_exp(2, 0, 1'b0, 1'b0);
    send(2'b01, 1'b1, 2);
    push_exp(3, 0, 1'b0, 1'b0);
    send(2'b01, 1'b1, 3);
    push_exp(4, 0, 1'b1, 1'b0);
    send(2'b01, 1'b1, 4);
    send(2'b01, 1'b1, 50);
    send(2'b01, 1'b1, 60);
    drain(10);
    check("busy_mid_store", int'(busy), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst2_in_rdy", int'(in_rdy), 0);
    check("rst2_out_vld", int'(out_vld), 0);
    check("rst2_busy", int'(busy), 0);
    check("rst2_last", int'(out_last), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst2_rdy_after", int'(in_rdy), 1);
    @(posedge clk);
    #1;
    send_block(2'b00, 1'b0, '{1, 1, 1, 1, 0, 0, 0, 0}, '{1, 1, 1, 1}, 4'b0000);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
